mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
- Multicycle MIPS control FSM. It is the initiator side of the behavioural ALU interface.
- Decodes opcode/funct from the IR and sequences fetch, decode, execute, memory and writeback.
- Drives the ALU control code and the datapath mux selects and enables.
- Consumes the ALU Zero and Overflow flags for branch resolution and overflow exceptions. Talks to a single memory port through a req/ready handshake.

Parameters:
- CTR_SIZE, 4, width of the ALU control code.
- EXC_EN, 1, when 0 the ALU overflow flag is ignored and no overflow exception is raised.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU Zero flag.
- overflow  in  1  ALU Overflow flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- alu_ctr  out  CTR_SIZE  ALU operation code.
- alu_src_a  out  1  0=PC, 1=register A.
- alu_src_b  out  2  0=register B, 1=const 4, 2=extended imm, 3=sext imm<<2.
- zext_imm  out  1  immediate is zero-extended (andi/ori/xori).
- ir_write, pc_write, iord, mem_read, mem_write  out  1 each  datapath enables.
- reg_write, reg_dst, mem_to_reg  out  1 each  register-file controls.
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=exception vector.
- epc_write  out  1  capture PC into EPC.
- cause  out  2  00 none, 01 overflow, 10 illegal instruction; held until the next exception.
- state_o  out  4  current state, for debug.

Behaviour:
- Moore FSM. Outputs decode from state plus opcode/funct. Exceptions: the handshake-gated enables and the branch pc_write.
- Any output not listed for a state is 0 in that state. alu_ctr defaults to NOP.
- ALU Carry_in is tied 0 at the top level.
- Reset (rst_n low, asynchronous): state=IDLE, cause=00, all outputs 0, alu_ctr=NOP.
- IDLE: all outputs 0. Next cycle goes to FETCH.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctr=ADDU, pc_source=0.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready, then DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=3, alu_ctr=ADDU (branch target into ALUOut).
  - Dispatch on opcode:
    - lw/sw -> MEM_ADDR
    - R-type -> EXEC_R
    - addi/addiu/slti/sltiu/andi/ori/xori -> EXEC_I
    - beq/bne -> BRANCH
    - j -> JUMP
    - otherwise -> EXCEPT with cause=10.
  - An unknown funct on R-type also goes to EXCEPT with cause=10.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADDU. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WRITE: mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- EXEC_R:
  - alu_src_a=1, alu_src_b=0.
  - funct mapping: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x2A SLT, 0x2B SLTU.
  - Shifts 0x00 SLL, 0x02 SRL, 0x03 SRA use alu_src_a=1 and alu_src_b=2, so the shamt reaches ALU B[10:6].
- EXEC_I:
  - alu_src_a=1, alu_src_b=2.
  - opcode mapping: addi ADD, addiu ADDU, slti SLT, sltiu SLTU, andi AND (zext_imm=1), ori OR (zext_imm=1), xori XOR (zext_imm=1).
- Leaving EXEC_R/EXEC_I: if EXC_EN and overflow and the op is ADD, SUB or addi, go to EXCEPT with cause=01 and no writeback. Otherwise go to WB.
- WB: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type and 0 for I-type. Next state FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_ctr=SUBU (no overflow trap), pc_source=1.
  - pc_write=(beq&zero)|(bne&~zero).
  - Next state FETCH.
- JUMP: pc_write=1, pc_source=2. Next state FETCH.
- EXCEPT:
  - epc_write=1 (EPC gets the already-incremented PC), pc_write=1, pc_source=3.
  - cause is updated on entry. Next state FETCH.
- Latency with zero-wait memory:
  - R-type and I-type ALU ops: 4 cycles.
  - lw: 5 cycles. sw: 4 cycles.
  - beq/bne and j: 3 cycles. Exception: 3 cycles.
  - Each cycle that mem_ready is low adds one cycle.
- Reset mid-operation: immediate return to IDLE. No write enable may glitch high after rst_n falls.

Decomposition:
- Shared package/defines file holds:
  - ALU codes: ADD=0, ADDU=1, SUB=2, SUBU=3, AND=4, OR=5, XOR=6, SLT=7, SLTU=8, SLL=9, SRL=A, SRA=B, NOP=F.
  - Opcode/funct constants (lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, addi..xori 0x08..0x0E).
  - State encodings.
- The ALU module includes the same file.
- One sub-module, mips_alu_dec: combinational opcode/funct to alu_ctr/zext_imm/legal.

Test Plan:
- Reset then add (funct 0x20), mem_ready=1 -> states IDLE,FETCH,DECODE,EXEC_R,WB. alu_ctr=0 in EXEC_R. reg_write=1,reg_dst=1 in WB only.
- lw with mem_ready held low 2 cycles in MEM_READ -> mem_read=1 and iord=1 for 3 cycles, then one MEM_WB with reg_write=1,mem_to_reg=1. Total 7 cycles.
- beq with zero=1 -> pc_write=1,pc_source=1 in BRANCH. bne with zero=1 -> pc_write=0. alu_ctr=SUBU (3) in both.
- addi with overflow=1 in EXEC_I -> EXCEPT next, epc_write=1, pc_source=3, cause=01, reg_write never asserted. Repeat with EXC_EN=0 -> WB with reg_write=1.
- opcode 0x3F -> DECODE then EXCEPT, cause=10. R-type funct 0x3F -> same result.
- rst_n pulsed low during MEM_WRITE -> all outputs 0 immediately, state_o=IDLE, mem_write drops asynchronously. Fetch resumes 1 cycle after rst_n rises.

Source files
------------

// File: rtl/mips_mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: ALU codes, opcode/funct
// values, FSM state encodings and the bundled control-word type.
package mips_mc_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0, ALU_ADDU = 4'h1, ALU_SUB  = 4'h2, ALU_SUBU = 4'h3;
  localparam logic [3:0] ALU_AND  = 4'h4, ALU_OR   = 4'h5, ALU_XOR  = 4'h6, ALU_SLT  = 4'h7;
  localparam logic [3:0] ALU_SLTU = 4'h8, ALU_SLL  = 4'h9, ALU_SRL  = 4'hA, ALU_SRA  = 4'hB;
  localparam logic [3:0] ALU_NOP  = 4'hF;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ  = 6'h04, OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR   = 6'h25, FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [3:0] S_IDLE     = 4'd0,  S_FETCH  = 4'd1,  S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3,  S_MEM_RD = 4'd4,  S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6,  S_EXEC_R = 4'd7,  S_EXEC_I   = 4'd8;
  localparam logic [3:0] S_WB       = 4'd9,  S_BRANCH = 4'd10, S_JUMP     = 4'd11;
  localparam logic [3:0] S_EXCEPT   = 4'd12;

  localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_OVF = 2'b01, CAUSE_ILL = 2'b10;

  typedef struct packed {
    logic [3:0] alu;
    logic       src_a;
    logic [1:0] src_b;
    logic       zext;
    logic       ir_write;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic       epc_write;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_dec.sv
// Combinational opcode/funct decode: ALU operation, immediate extension mode,
// instruction legality and whether the op is a shamt-driven shift.
module mips_alu_dec import mips_mc_ctrl_pkg::*; (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctr,
  output logic       zext_imm,
  output logic       legal,
  output logic       shift
);

  always_comb begin
    alu_ctr  = ALU_NOP;
    zext_imm = 1'b0;
    legal    = 1'b1;
    shift    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_ctr = ALU_ADD;
          FN_ADDU: alu_ctr = ALU_ADDU;
          FN_SUB:  alu_ctr = ALU_SUB;
          FN_SUBU: alu_ctr = ALU_SUBU;
          FN_AND:  alu_ctr = ALU_AND;
          FN_OR:   alu_ctr = ALU_OR;
          FN_XOR:  alu_ctr = ALU_XOR;
          FN_SLT:  alu_ctr = ALU_SLT;
          FN_SLTU: alu_ctr = ALU_SLTU;
          FN_SLL:  begin alu_ctr = ALU_SLL; shift = 1'b1; end
          FN_SRL:  begin alu_ctr = ALU_SRL; shift = 1'b1; end
          FN_SRA:  begin alu_ctr = ALU_SRA; shift = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI:  alu_ctr = ALU_ADD;
      OP_ADDIU: alu_ctr = ALU_ADDU;
      OP_SLTI:  alu_ctr = ALU_SLT;
      OP_SLTIU: alu_ctr = ALU_SLTU;
      OP_ANDI:  begin alu_ctr = ALU_AND; zext_imm = 1'b1; end
      OP_ORI:   begin alu_ctr = ALU_OR;  zext_imm = 1'b1; end
      OP_XORI:  begin alu_ctr = ALU_XOR; zext_imm = 1'b1; end
      // Memory, branch and jump ops are legal but set their ALU op per state.
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing,
// datapath selects, branch resolution and overflow/illegal-instruction exceptions.
module mips_mc_ctrl import mips_mc_ctrl_pkg::*; #(
  parameter int CTR_SIZE = 4,
  parameter bit EXC_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                overflow,
  input  logic                mem_ready,
  output logic [CTR_SIZE-1:0] alu_ctr,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                zext_imm,
  output logic                ir_write,
  output logic                pc_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic [1:0]          pc_source,
  output logic                epc_write,
  output logic [1:0]          cause,
  output logic [3:0]          state_o
);

  logic [3:0] state, state_nxt;
  logic [1:0] cause_r, cause_nxt;
  logic [3:0] dec_alu;
  logic       dec_zext, dec_legal, dec_shift, ovf_trap;
  ctrl_t      c;

  mips_alu_dec u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .alu_ctr  (dec_alu),
    .zext_imm (dec_zext),
    .legal    (dec_legal),
    .shift    (dec_shift)
  );

  // Only signed add/sub (add, sub, addi) trap; addi decodes to ALU_ADD.
  assign ovf_trap = EXC_EN && overflow && (dec_alu == ALU_ADD || dec_alu == ALU_SUB);

  always_comb begin
    state_nxt = state;
    cause_nxt = cause_r;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!dec_legal) begin
          state_nxt = S_EXCEPT;
          cause_nxt = CAUSE_ILL;
        end else begin
          case (opcode)
            OP_LW, OP_SW:   state_nxt = S_MEM_ADDR;
            OP_RTYPE:       state_nxt = S_EXEC_R;
            OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
            OP_J:           state_nxt = S_JUMP;
            default:        state_nxt = S_EXEC_I;
          endcase
        end
      end
      S_MEM_ADDR: state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
      S_EXEC_R, S_EXEC_I: begin
        if (ovf_trap) begin
          state_nxt = S_EXCEPT;
          cause_nxt = CAUSE_OVF;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM_WB, S_WB, S_BRANCH, S_JUMP, S_EXCEPT: state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cause_r <= CAUSE_NONE;
    end else begin
      state   <= state_nxt;
      cause_r <= cause_nxt;
    end
  end

  always_comb begin
    c     = '0;
    c.alu = ALU_NOP;
    case (state)
      S_FETCH: begin
        c.mem_read = 1'b1;
        c.src_b    = 2'd1;
        c.alu      = ALU_ADDU;
        c.ir_write = mem_ready;
        c.pc_write = mem_ready;
      end
      S_DECODE: begin
        c.src_b = 2'd3;
        c.alu   = ALU_ADDU;
      end
      S_MEM_ADDR: begin
        c.src_a = 1'b1;
        c.src_b = 2'd2;
        c.alu   = ALU_ADDU;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      // Shifts take shamt through the extended-immediate path on ALU B.
      S_EXEC_R: begin
        c.src_a = 1'b1;
        c.src_b = dec_shift ? 2'd2 : 2'd0;
        c.alu   = dec_alu;
      end
      S_EXEC_I: begin
        c.src_a = 1'b1;
        c.src_b = 2'd2;
        c.alu   = dec_alu;
        c.zext  = dec_zext;
      end
      S_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = (opcode == OP_RTYPE);
      end
      S_BRANCH: begin
        c.src_a     = 1'b1;
        c.alu       = ALU_SUBU;
        c.pc_source = 2'd1;
        c.pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'd2;
      end
      S_EXCEPT: begin
        c.epc_write = 1'b1;
        c.pc_write  = 1'b1;
        c.pc_source = 2'd3;
      end
      default: ;
    endcase
  end

  assign alu_ctr    = CTR_SIZE'(c.alu);
  assign alu_src_a  = c.src_a;
  assign alu_src_b  = c.src_b;
  assign zext_imm   = c.zext;
  assign ir_write   = c.ir_write;
  assign pc_write   = c.pc_write;
  assign iord       = c.iord;
  assign mem_read   = c.mem_read;
  assign mem_write  = c.mem_write;
  assign reg_write  = c.reg_write;
  assign reg_dst    = c.reg_dst;
  assign mem_to_reg = c.mem_to_reg;
  assign pc_source  = c.pc_source;
  assign epc_write  = c.epc_write;
  assign cause      = cause_r;
  assign state_o    = state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle vector table over an instruction
// stream, plus hand sequences for EXC_EN=0 and asynchronous reset mid-store.
module tb_mips_mc_ctrl;

  localparam logic [3:0] IDL = 4'd0, FET = 4'd1, DEC = 4'd2, MAD = 4'd3, MRD = 4'd4, MWB = 4'd5;
  localparam logic [3:0] MWR = 4'd6, EXR = 4'd7, EXI = 4'd8, WBK = 4'd9, BRA = 4'd10, JMP = 4'd11;
  localparam logic [3:0] EXC = 4'd12;
  localparam logic [3:0] A_ADD = 4'h0, A_ADDU = 4'h1, A_SUB = 4'h2, A_SUBU = 4'h3, A_OR = 4'h5;
  localparam logic [3:0] A_SLL = 4'h9, A_NOP = 4'hF;
  localparam logic [1:0] B_REG = 2'd0, B_4 = 2'd1, B_IMM = 2'd2, B_BR = 2'd3;
  localparam logic [1:0] P_ALU = 2'd0, P_OUT = 2'd1, P_JMP = 2'd2, P_EXC = 2'd3;
  localparam logic [1:0] C_NO = 2'd0, C_OV = 2'd1, C_IL = 2'd2;
  // Enable order: zext, ir_write, pc_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, epc_write
  localparam logic [9:0] E0   = 10'b0000000000, EFET = 10'b0110100000, EFST = 10'b0000100000;
  localparam logic [9:0] EMRD = 10'b0001100000, EMWB = 10'b0000001010, EWBR = 10'b0000001100;
  localparam logic [9:0] EWBI = 10'b0000001000, EPCW = 10'b0010000000, EEXC = 10'b0010000001;
  localparam logic [9:0] EZX  = 10'b1000000000;

  typedef struct packed {
    logic rdy; logic [5:0] op; logic [5:0] fn; logic z; logic ov;
    logic [3:0] st; logic [3:0] alu; logic sa; logic [1:0] sb; logic [1:0] pcs;
    logic [9:0] en; logic [1:0] cs;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, overflow = 1'b0, mem_ready = 1'b0;

  logic [3:0] alu_ctr, state_o, alu_ctr_1, state_o_1;
  logic [1:0] alu_src_b, pc_source, cause, alu_src_b_1, pc_source_1, cause_1;
  logic alu_src_a, zext_imm, ir_write, pc_write, iord, mem_read, mem_write;
  logic reg_write, reg_dst, mem_to_reg, epc_write;
  logic alu_src_a_1, zext_imm_1, ir_write_1, pc_write_1, iord_1, mem_read_1, mem_write_1;
  logic reg_write_1, reg_dst_1, mem_to_reg_1, epc_write_1;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.CTR_SIZE(4), .EXC_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
    .mem_ready(mem_ready), .alu_ctr(alu_ctr), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .zext_imm(zext_imm), .ir_write(ir_write), .pc_write(pc_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .pc_source(pc_source), .epc_write(epc_write), .cause(cause),
    .state_o(state_o));

  mips_mc_ctrl #(.CTR_SIZE(4), .EXC_EN(1'b0)) dut_noexc (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
    .mem_ready(mem_ready), .alu_ctr(alu_ctr_1), .alu_src_a(alu_src_a_1), .alu_src_b(alu_src_b_1),
    .zext_imm(zext_imm_1), .ir_write(ir_write_1), .pc_write(pc_write_1), .iord(iord_1),
    .mem_read(mem_read_1), .mem_write(mem_write_1), .reg_write(reg_write_1), .reg_dst(reg_dst_1),
    .mem_to_reg(mem_to_reg_1), .pc_source(pc_source_1), .epc_write(epc_write_1), .cause(cause_1),
    .state_o(state_o_1));

  logic [24:0] act;
  assign act = {state_o, alu_ctr, alu_src_a, alu_src_b, pc_source, zext_imm, ir_write, pc_write,
                iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, epc_write, cause};

  int errors = 0, checks = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, a, e);
    end
  endtask

  function automatic vec_t v(input logic rdy, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic ov, input logic [3:0] st,
                             input logic [3:0] alu, input logic sa, input logic [1:0] sb,
                             input logic [1:0] pcs, input logic [9:0] en, input logic [1:0] cs);
    vec_t r;
    r.rdy = rdy; r.op = op; r.fn = fn; r.z = z; r.ov = ov; r.st = st; r.alu = alu;
    r.sa = sa; r.sb = sb; r.pcs = pcs; r.en = en; r.cs = cs;
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // add
    tbl.push_back(v(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, IDL, A_NOP,  1'b0, B_REG, P_ALU, E0,   C_NO));
    tbl.push_back(v(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFET, C_NO));
    tbl.push_back(v(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, DEC, A_ADDU, 1'b0, B_BR,  P_ALU, E0,   C_NO));
    tbl.push_back(v(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, EXR, A_ADD,  1'b1, B_REG, P_ALU, E0,   C_NO));
    tbl.push_back(v(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, WBK, A_NOP,  1'b0, B_REG, P_ALU, EWBR, C_NO));
    // lw, two wait cycles in MEM_READ
    tbl.push_back(v(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFET, C_NO));
    tbl.push_back(v(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, DEC, A_ADDU, 1'b0, B_BR,  P_ALU, E0,   C_NO));
    tbl.push_back(v(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, MAD, A_ADDU, 1'b1, B_IMM, P_ALU, E0,   C_NO));
    tbl.push_back(v(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, MRD, A_NOP,  1'b0, B_REG, P_ALU, EMRD, C_NO));
    tbl.push_back(v(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, MRD, A_NOP,  1'b0, B_REG, P_ALU, EMRD, C_NO));
    tbl.push_back(v(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, MRD, A_NOP,  1'b0, B_REG, P_ALU, EMRD, C_NO));
    tbl.push_back(v(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, MWB, A_NOP,  1'b0, B_REG, P_ALU, EMWB, C_NO));
    // beq taken, one fetch wait
    tbl.push_back(v(1'b0, 6'h04, 6'h00, 1'b1, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFST, C_NO));
    tbl.push_back(v(1'b1, 6'h04, 6'h00, 1'b1, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFET, C_NO));
    tbl.push_back(v(1'b1, 6'h04, 6'h00, 1'b1, 1'b0, DEC, A_ADDU, 1'b0, B_BR,  P_ALU, E0,   C_NO));
    tbl.push_back(v(1'b1, 6'h04, 6'h00, 1'b1, 1'b0, BRA, A_SUBU, 1'b1, B_REG, P_OUT, EPCW, C_NO));
    // bne with zero=1 (not taken), then zero=0 (taken)
    tbl.push_back(v(1'b1, 6'h05, 6'h00, 1'b1, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFET, C_NO));
    tbl.push_back(v(1'b1, 6'h05, 6'h00, 1'b1, 1'b0, DEC, A_ADDU, 1'b0, B_BR,  P_ALU, E0,   C_NO));
    tbl.push_back(v(1'b1, 6'h05, 6'h00, 1'b1, 1'b0, BRA, A_SUBU, 1'b1, B_REG, P_OUT, E0,   C_NO));
    tbl.push_back(v(1'b1, 6'h05, 6'h00, 1'b0, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFET, C_NO));
    tbl.push_back(v(1'b1, 6'h05, 6'h00, 1'b0, 1'b0, DEC, A_ADDU, 1'b0, B_BR,  P_ALU, E0,   C_NO));
    tbl.push_back(v(1'b1, 6'h05, 6'h00, 1'b0, 1'b0, BRA, A_SUBU, 1'b1, B_REG, P_OUT, EPCW, C_NO));
    // j
    tbl.push_back(v(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFET, C_NO));
    tbl.push_back(v(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, DEC, A_ADDU, 1'b0, B_BR,  P_ALU, E0,   C_NO));
    tbl.push_back(v(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, JMP, A_NOP,  1'b0, B_REG, P_JMP, EPCW, C_NO));
    // addi overflowing
    tbl.push_back(v(1'b1, 6'h08, 6'h00, 1'b0, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFET, C_NO));
    tbl.push_back(v(1'b1, 6'h08, 6'h00, 1'b0, 1'b0, DEC, A_ADDU, 1'b0, B_BR,  P_ALU, E0,   C_NO));
    tbl.push_back(v(1'b1, 6'h08, 6'h00, 1'b0, 1'b1, EXI, A_ADD,  1'b1, B_IMM, P_ALU, E0,   C_NO));
    tbl.push_back(v(1'b1, 6'h08, 6'h00, 1'b0, 1'b0, EXC, A_NOP,  1'b0, B_REG, P_EXC, EEXC, C_OV));
    // R-type with unknown funct
    tbl.push_back(v(1'b1, 6'h00, 6'h3F, 1'b0, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFET, C_OV));
    tbl.push_back(v(1'b1, 6'h00, 6'h3F, 1'b0, 1'b0, DEC, A_ADDU, 1'b0, B_BR,  P_ALU, E0,   C_OV));
    tbl.push_back(v(1'b1, 6'h00, 6'h3F, 1'b0, 1'b0, EXC, A_NOP,  1'b0, B_REG, P_EXC, EEXC, C_IL));
    // ori: zero-extended, overflow flag irrelevant
    tbl.push_back(v(1'b1, 6'h0D, 6'h00, 1'b0, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFET, C_IL));
    tbl.push_back(v(1'b1, 6'h0D, 6'h00, 1'b0, 1'b0, DEC, A_ADDU, 1'b0, B_BR,  P_ALU, E0,   C_IL));
    tbl.push_back(v(1'b1, 6'h0D, 6'h00, 1'b0, 1'b1, EXI, A_OR,   1'b1, B_IMM, P_ALU, EZX,  C_IL));
    tbl.push_back(v(1'b1, 6'h0D, 6'h00, 1'b0, 1'b0, WBK, A_NOP,  1'b0, B_REG, P_ALU, EWBI, C_IL));
    // sub overflowing
    tbl.push_back(v(1'b1, 6'h00, 6'h22, 1'b0, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFET, C_IL));
    tbl.push_back(v(1'b1, 6'h00, 6'h22, 1'b0, 1'b0, DEC, A_ADDU, 1'b0, B_BR,  P_ALU, E0,   C_IL));
    tbl.push_back(v(1'b1, 6'h00, 6'h22, 1'b0, 1'b1, EXR, A_SUB,  1'b1, B_REG, P_ALU, E0,   C_IL));
    tbl.push_back(v(1'b1, 6'h00, 6'h22, 1'b0, 1'b0, EXC, A_NOP,  1'b0, B_REG, P_EXC, EEXC, C_OV));
    // sll: shamt via immediate path
    tbl.push_back(v(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFET, C_OV));
    tbl.push_back(v(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, DEC, A_ADDU, 1'b0, B_BR,  P_ALU, E0,   C_OV));
    tbl.push_back(v(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, EXR, A_SLL,  1'b1, B_IMM, P_ALU, E0,   C_OV));
    tbl.push_back(v(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, WBK, A_NOP,  1'b0, B_REG, P_ALU, EWBR, C_OV));
    // unknown opcode
    tbl.push_back(v(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, FET, A_ADDU, 1'b0, B_4,   P_ALU, EFET, C_OV));
    tbl.push_back(v(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, DEC, A_ADDU, 1'b0, B_BR,  P_ALU, E0,   C_OV));
    tbl.push_back(v(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, EXC, A_NOP,  1'b0, B_REG, P_EXC, EEXC, C_IL));

    #3;
    chk("reset_outputs", 32'(act), 32'({IDL, A_NOP, 1'b0, B_REG, P_ALU, E0, C_NO}));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      mem_ready = tbl[i].rdy; opcode = tbl[i].op; funct = tbl[i].fn;
      zero = tbl[i].z; overflow = tbl[i].ov;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(act),
          32'({tbl[i].st, tbl[i].alu, tbl[i].sa, tbl[i].sb, tbl[i].pcs, tbl[i].en, tbl[i].cs}));
      step();
    end

    // addi overflow on both builds: only the trapping one raises the exception
    mem_ready = 1'b1; opcode = 6'h08; funct = 6'h00; zero = 1'b0; overflow = 1'b1;
    step(); step();
    @(negedge clk);
    chk("noexc_exec_i", 32'({state_o_1, reg_write_1}), 32'({EXI, 1'b0}));
    step();
    @(negedge clk);
    chk("noexc_wb", 32'({state_o_1, reg_write_1, reg_dst_1}), 32'({WBK, 1'b1, 1'b0}));
    chk("noexc_cause_kept", 32'(cause_1), 32'(C_IL));
    chk("exc_except", 32'({state_o, reg_write, epc_write, pc_source, cause}),
        32'({EXC, 1'b0, 1'b1, P_EXC, C_OV}));
    step();

    // sw, then asynchronous reset while the write is waiting on memory
    opcode = 6'h2B; overflow = 1'b0;
    step(); step();
    mem_ready = 1'b0;
    step();
    @(negedge clk);
    chk("sw_mem_write", 32'({state_o, mem_write, iord}), 32'({MWR, 1'b1, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(act), 32'({IDL, A_NOP, 1'b0, B_REG, P_ALU, E0, C_NO}));
    @(posedge clk); #1;
    chk("rst_held_idle", 32'({state_o, mem_write}), 32'({IDL, 1'b0}));
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", 32'(state_o), 32'(IDL));
    step();
    chk("fetch_resumes", 32'({state_o, mem_read}), 32'({FET, 1'b1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
